// File: rtl/uart_rx_fifo_pkg.sv
// Shared constants for the UART receive FIFO and its storage sub-module.
// Optional drop statistics are enabled by defining UART_RX_FIFO_STATS_EN.
package uart_rx_fifo_pkg;
   localparam int UART_DWIDTH        = 8;
   localparam int UART_RX_FIFO_DEPTH = 8;
   localparam int DROP_CNT_WIDTH     = 16;
endpackage

// File: rtl/uart_rx_fifo_mem.sv
// Register-array storage for the UART receive FIFO.
// Writes are synchronous and the read port is combinational, so the head entry is visible without delay.
module fifo_mem
   import uart_rx_fifo_pkg::*;
#(
   parameter int DWIDTH = UART_DWIDTH,
   parameter int DEPTH  = UART_RX_FIFO_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_in,
   input  logic [AW-1:0]     waddr_in,
   input  logic [DWIDTH-1:0] wdata_in,
   input  logic [AW-1:0]     raddr_in,
   output logic [DWIDTH-1:0] rdata_out
);

   logic [DWIDTH-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_in) begin
         mem_q[waddr_in] <= wdata_in;
      end
   end

   assign rdata_out = mem_q[raddr_in];

endmodule

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through receive buffer between the UART receiver and the MMIO block.
// Define UART_RX_FIFO_STATS_EN to add a saturating dropped-byte counter (drop_count_out).
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DWIDTH = UART_DWIDTH,
   parameter int DEPTH  = UART_RX_FIFO_DEPTH,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [DWIDTH-1:0]         enq_data_in,
   input  logic                      enq_valid_in,
   output logic                      enq_ready_out,
   output logic [DWIDTH-1:0]         deq_data_out,
   output logic                      deq_valid_out,
   input  logic                      deq_ready_in,
   input  logic                      clear_in,
   output logic [AW:0]               count_out,
`ifdef UART_RX_FIFO_STATS_EN
   output logic [DROP_CNT_WIDTH-1:0] drop_count_out,
`endif
   output logic                      overflow_out
);

   localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic        overflow_q, overflow_d;
   logic        full, empty;
   logic        enq_fire, deq_fire, drop_event;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);

   // A full FIFO never accepts a byte, even when the head is popped this cycle.
   assign enq_fire   = enq_valid_in && !full && !clear_in;
   assign deq_fire   = deq_ready_in && !empty && !clear_in;
   assign drop_event = enq_valid_in && full && !clear_in;

   always_comb begin
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      overflow_d = overflow_q;
      if (clear_in) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         overflow_d = 1'b0;
      end else begin
         if (enq_fire)   wr_ptr_d   = wr_ptr_q + PTR_ONE;
         if (deq_fire)   rd_ptr_d   = rd_ptr_q + PTR_ONE;
         if (drop_event) overflow_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
      end
   end

   fifo_mem #(
      .DWIDTH (DWIDTH),
      .DEPTH  (DEPTH)
   ) u_mem (
      .clk       (clk),
      .we_in     (enq_fire),
      .waddr_in  (wr_ptr_q[AW-1:0]),
      .wdata_in  (enq_data_in),
      .raddr_in  (rd_ptr_q[AW-1:0]),
      .rdata_out (deq_data_out)
   );

   assign enq_ready_out = !full;
   assign deq_valid_out = !empty;
   assign count_out     = wr_ptr_q - rd_ptr_q;
   assign overflow_out  = overflow_q;

`ifdef UART_RX_FIFO_STATS_EN
   logic [DROP_CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (clear_in) begin
         drop_cnt_d = '0;
      end else if (drop_event && (drop_cnt_q != '1)) begin
         drop_cnt_d = drop_cnt_q + DROP_CNT_WIDTH'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         drop_cnt_q <= '0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_count_out = drop_cnt_q;
`endif

endmodule
